// File: rtl/fetch_pkg.sv
// Shared types for the decoupled instruction fetch stage.
// Holds the fetch FSM states, the instruction width and the queue entry layout.
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0] instr;
    } queue_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with async active-high reset and flush.
// Ports: clock, reset, push/din, pop/dout (head), flush, full, empty, count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch stage: sequential word fetches, response queue, redirect flush.
// Ports: clock/reset; imem request (imemReq/imemAddr/imemReady) and response
// (imemValid/imemData); datapath side (instrValid/instruction/instrPC/instrReady);
// redirect/redirectPC from the branch unit.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imemReq,
    output logic [INSTR_WIDTH-1:0] imemAddr,
    input  logic                   imemReady,
    input  logic                   imemValid,
    input  logic [INSTR_WIDTH-1:0] imemData,
    output logic                   instrValid,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [INSTR_WIDTH-1:0] instrPC,
    input  logic                   instrReady,
    input  logic                   redirect,
    input  logic [INSTR_WIDTH-1:0] redirectPC
);

    localparam int             CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEPTH);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [INSTR_WIDTH-1:0] fetch_pc;
    logic [INSTR_WIDTH-1:0] fetch_pc_next;
    logic [CNT_W-1:0]       drop_count;
    logic [CNT_W-1:0]       drop_next;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       occupancy;

    logic                   handshake;
    logic                   response;
    logic                   credit;

    logic                   q_push;
    logic                   q_pop;
    logic                   q_full;
    logic                   q_empty;
    queue_entry_t           q_din;
    queue_entry_t           q_dout;

    logic [INSTR_WIDTH-1:0] tag_pc;
    logic                   tag_full;
    logic                   tag_empty;

    // Every issued request reserves a queue slot, so the queue never overflows.
    assign credit    = ({1'b0, occupancy} + {1'b0, outstanding}) < LIMIT;
    assign imemReq   = ~reset & (state == FETCH) & credit;
    assign imemAddr  = fetch_pc;
    assign handshake = imemReq & imemReady;
    // A response with nothing in flight is ignored.
    assign response  = imemValid & ~tag_empty;

    assign q_push = response & (state == FETCH) & ~redirect;
    assign q_pop  = instrValid & instrReady & ~redirect;
    assign q_din  = '{pc: tag_pc, instr: imemData};

    assign instrValid  = ~q_empty;
    assign instruction = instrValid ? q_dout.instr : '0;
    assign instrPC     = instrValid ? q_dout.pc : '0;

    // The tag FIFO is never flushed: it must stay aligned with the memory's
    // in-order responses, including the ones dropped after a redirect.
    fetch_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock (clock),
        .reset (reset),
        .push  (handshake),
        .pop   (response),
        .flush (1'b0),
        .din   (fetch_pc),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(queue_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clock (clock),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            drop_count <= drop_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        drop_next     = drop_count;
        if (handshake) fetch_pc_next = fetch_pc + 32'd4;
        unique case (state)
            FETCH: state_next = FETCH;
            DRAIN: begin
                if (response) begin
                    drop_next = drop_count - CNT_W'(1);
                    if (drop_count <= CNT_W'(1)) state_next = FETCH;
                end
            end
        endcase
        // Everything still in flight after this edge belongs to the old path.
        if (redirect) begin
            fetch_pc_next = {redirectPC[31:2], 2'b00};
            drop_next     = outstanding + CNT_W'(handshake) - CNT_W'(response);
            state_next    = (drop_next != '0) ? DRAIN : FETCH;
        end
    end

    a_rsp_in_flight: assert property (
        @(posedge clock) disable iff (reset) imemValid |-> !tag_empty);

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        (q_push |-> (!q_full || q_pop)) and (handshake |-> !tag_full));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised bench for instruction_fetch_queue with an epoch-based model.
// Memory model returns in-order responses; scoreboard checks every cycle.
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectPC;

    instruction_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemValid   (imemValid),
        .imemData    (imemData),
        .instrValid  (instrValid),
        .instruction (instruction),
        .instrPC     (instrPC),
        .instrReady  (instrReady),
        .redirect    (redirect),
        .redirectPC  (redirectPC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] expq[$];
    logic [31:0] exp_addr;
    logic [31:0] last_hs_addr;
    logic [31:0] tgt;
    int          epoch;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          p_ready;
    int          p_mready;
    int          p_redir;
    int          lat_lo;
    int          lat_hi;
    int          first_req;
    int          first_val;
    bit          one_redir;
    bit          redir_both;
    bit          saw_wrap;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit   stale;
        bit   exp_req;
        bit   hs;
        bit   rsp;
        bit   cons;
        req_t r;
        r = '{32'h0, 0, 0};
        @(negedge clock);
        stale = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale = 1'b1;
        exp_req = !stale && (expq.size() + mem_q.size() < DEPTH);
        chk("imemReq", imemReq, exp_req);
        if (exp_req) chk("imemAddr", imemAddr, exp_addr);
        chk("instrValid", instrValid, expq.size() != 0);
        if (expq.size() != 0) begin
            chk("instrPC", instrPC, expq[0]);
            chk("instruction", instruction, mem_word(expq[0]));
        end
        if (imemReq && first_req < 0) first_req = cyc;
        if (instrValid && first_val < 0) first_val = cyc;

        instrReady = ($urandom_range(99) < p_ready);
        imemReady  = ($urandom_range(99) < p_mready);
        imemValid  = 1'b0;
        imemData   = $urandom;
        rsp        = 1'b0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            r         = mem_q.pop_front();
            imemValid = 1'b1;
            imemData  = mem_word(r.addr);
            rsp       = 1'b1;
        end
        hs = imemReq && imemReady;
        redirect   = 1'b0;
        redirectPC = $urandom;
        if (one_redir) begin
            redirect   = 1'b1;
            redirectPC = tgt;
            one_redir  = 1'b0;
        end else if (redir_both && hs && rsp) begin
            redirect   = 1'b1;
            redirectPC = tgt;
            redir_both = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect = 1'b1;
        end

        cons = (expq.size() != 0) && instrReady && !redirect;
        if (cons) void'(expq.pop_front());
        if (rsp && r.epoch == epoch && !redirect) expq.push_back(r.addr);
        if (hs) begin
            if (imemAddr == 32'h0 && last_hs_addr == 32'hFFFF_FFFC)
                saw_wrap = 1'b1;
            last_hs_addr = imemAddr;
            mem_q.push_back('{exp_addr,
                              cyc + int'($urandom_range(lat_hi, lat_lo)),
                              epoch});
            exp_addr = exp_addr + 32'd4;
        end
        if (redirect) begin
            exp_addr = {redirectPC[31:2], 2'b00};
            epoch++;
            expq.delete();
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imemReady  = 1'b0;
        imemValid  = 1'b0;
        imemData   = 32'h0;
        instrReady = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        mem_q.delete();
        expq.delete();
        exp_addr     = RESET_PC;
        last_hs_addr = 32'h0;
        epoch        = 0;
        first_req    = -1;
        first_val    = -1;
        repeat (2) @(negedge clock);
        chk("rst_imemReq", imemReq, 1'b0);
        chk("rst_imemAddr", imemAddr, RESET_PC);
        chk("rst_instrValid", instrValid, 1'b0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instrPC", instrPC, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        p_ready    = 100;
        p_mready   = 100;
        p_redir    = 0;
        lat_lo     = 1;
        lat_hi     = 1;
        one_redir  = 1'b0;
        redir_both = 1'b0;
        saw_wrap   = 1'b0;
        tgt        = 32'h0;
        do_reset();

        repeat (12) step();
        chk("first_latency", 32'(first_val - first_req), 32'd2);

        p_ready = 0;
        repeat (12) step();
        chk("bp_req_low", imemReq, 1'b0);
        chk("bp_valid", instrValid, 1'b1);
        p_ready = 100;
        repeat (8) step();

        lat_lo   = 3;
        lat_hi   = 3;
        p_mready = 0;
        repeat (6) step();
        p_mready = 100;
        repeat (2) step();
        p_mready  = 0;
        tgt       = 32'h0000_0100;
        one_redir = 1'b1;
        step();
        p_mready = 100;
        repeat (14) step();

        lat_lo     = 1;
        lat_hi     = 1;
        tgt        = 32'h0000_0203;
        redir_both = 1'b1;
        repeat (12) step();

        tgt       = 32'hFFFF_FFF4;
        one_redir = 1'b1;
        repeat (10) step();
        chk("addr_wrap", saw_wrap, 1'b1);

        for (int k = 0; k < 1500; k++) begin
            if (k % 50 == 0) begin
                p_ready  = int'($urandom_range(100));
                p_mready = int'($urandom_range(100, 20));
                p_redir  = int'($urandom_range(6));
                lat_lo   = 1;
                lat_hi   = int'($urandom_range(5, 1));
            end
            step();
        end

        p_ready  = 0;
        p_mready = 100;
        p_redir  = 0;
        lat_lo   = 3;
        lat_hi   = 3;
        repeat (12) step();
        chk("pre_rst_valid", instrValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_imemReq", imemReq, 1'b0);
        chk("async_imemAddr", imemAddr, RESET_PC);
        chk("async_instrValid", instrValid, 1'b0);
        chk("async_instruction", instruction, 32'h0);
        chk("async_instrPC", instrPC, 32'h0);
        do_reset();
        p_ready = 100;
        lat_lo  = 1;
        lat_hi  = 1;
        repeat (12) step();
        chk("restart_latency", 32'(first_val - first_req), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
